dice_roll_gen: RTL

//  Upstream stage of the craps game FSM. Turns the raw roll push-button into one clean roll event per press.

---
 rtl/dice_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 57 +++++
 rtl/dice_roll_gen.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared definitions for the craps dice roll generator: die range,
// roll handshake state encoding and the die-counter step helper.
package dice_pkg;

    localparam logic [2:0] DIE_MIN = 3'd1;
    localparam logic [2:0] DIE_MAX = 3'd6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } roll_state_e;

    // Next value of a 1..6 die counter; 6 wraps back to 1.
    function automatic logic [2:0] die_next(input logic [2:0] v);
        logic [2:0] r;
        if (v == DIE_MAX) begin
            r = DIE_MIN;
        end else begin
            r = v + 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer for the
// raw roll push-button. The debounced level only flips after
// DEBOUNCE_CYCLES consecutive synchronised samples disagree with it.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count differing samples; flip the level once enough have been seen in a row.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = ~db_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchroniser and debounce state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/dice_roll_gen.sv
// Dice roll generator: debounces the roll button, captures two free-running
// 1..6 counters on each clean press and offers the roll to the game FSM
// over a valid/ready handshake. A held button yields exactly one roll.
module dice_roll_gen
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             roll_ready,
    output logic             roll_valid,
    output logic [2:0]       die_a,
    output logic [2:0]       die_b,
    output logic [3:0]       sum,
    output logic [CNT_W-1:0] roll_count
);

    localparam logic [CNT_W-1:0] COUNT_ONE = CNT_W'(1);

    logic             btn_db_s;
    roll_state_e      state_q;
    roll_state_e      state_d;
    logic [2:0]       cnt_a_q;
    logic [2:0]       cnt_a_d;
    logic [2:0]       cnt_b_q;
    logic [2:0]       cnt_b_d;
    logic             valid_q;
    logic             valid_d;
    logic [2:0]       die_a_q;
    logic [2:0]       die_a_d;
    logic [2:0]       die_b_q;
    logic [2:0]       die_b_d;
    logic [3:0]       sum_q;
    logic [3:0]       sum_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .btn_db (btn_db_s)
    );

    // Free-running dice: cnt_a steps every cycle, cnt_b steps when cnt_a wraps.
    always_comb begin
        cnt_a_d = die_next(cnt_a_q);
        if (cnt_a_q == DIE_MAX) begin
            cnt_b_d = die_next(cnt_b_q);
        end else begin
            cnt_b_d = cnt_b_q;
        end
    end

    // Roll handshake: capture on press, hold until accepted, wait for button release.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        die_a_d = die_a_q;
        die_b_d = die_b_q;
        sum_d   = sum_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (btn_db_s) begin
                    die_a_d = cnt_a_q;
                    die_b_d = cnt_b_q;
                    sum_d   = {1'b0, cnt_a_q} + {1'b0, cnt_b_q};
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (roll_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + COUNT_ONE;
                    state_d = RELEASE;
                end else begin
                    state_d = HOLD;
                end
            end
            RELEASE: begin
                if (!btn_db_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RELEASE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, dice counters, captured roll and accepted-roll count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_a_q <= DIE_MIN;
            cnt_b_q <= DIE_MIN;
            valid_q <= 1'b0;
            die_a_q <= 3'd0;
            die_b_q <= 3'd0;
            sum_q   <= 4'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            valid_q <= valid_d;
            die_a_q <= die_a_d;
            die_b_q <= die_b_d;
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end

    assign roll_valid = valid_q;
    assign die_a      = die_a_q;
    assign die_b      = die_b_q;
    assign sum        = sum_q;
    assign roll_count = count_q;

endmodule
